// File: rtl/de0_cv_pio_pkg.sv
// Shared definitions for the DE0-CV output PIO with valid/ack handshake:
// register offsets, STATUS bit positions and handshake FSM state encodings.
package de0_cv_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_OUTSET   = 2'd2;
    localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_OVERRUN = 2;
    localparam int ST_TIMEOUT = 3;
    localparam int ST_IRQ_EN  = 8;

    typedef enum logic [1:0] {
        HS_IDLE    = 2'd0,
        HS_REQ     = 2'd1,
        HS_ACKWAIT = 2'd2
    } hs_state_t;

    function automatic logic [31:0] status_word(
        input logic busy,
        input logic done,
        input logic overrun,
        input logic timeout,
        input logic irq_en
    );
        logic [31:0] w;
        w = '0;
        w[ST_BUSY]    = busy;
        w[ST_DONE]    = done;
        w[ST_OVERRUN] = overrun;
        w[ST_TIMEOUT] = timeout;
        w[ST_IRQ_EN]  = irq_en;
        return w;
    endfunction

endpackage

// File: rtl/de0_cv_pio_hs_fsm.sv
// 4-phase valid/ack handshake FSM with optional request timeout.
// Ports: clk, reset_n (async, active-low); launch starts a transfer from IDLE;
//   out_ack is the external acknowledge; busy = not IDLE; out_valid registered,
//   high exactly in REQ; done_pulse / timeout_pulse flag transfer completion.
module de0_cv_pio_hs_fsm
    import de0_cv_pio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic launch,
    input  logic out_ack,
    output logic busy,
    output logic out_valid,
    output logic done_pulse,
    output logic timeout_pulse
);

    // A zero TIMEOUT_CYCLES would give a zero-width counter; keep one bit.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

    hs_state_t state, state_nx;
    logic [CW-1:0] count, count_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HS_IDLE;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            out_valid <= (state_nx == HS_REQ);
        end
    end

    always_comb begin
        state_nx      = state;
        count_nx      = count;
        done_pulse    = 1'b0;
        timeout_pulse = 1'b0;
        case (state)
            HS_IDLE: begin
                if (launch) begin
                    state_nx = HS_REQ;
                    count_nx = '0;
                end
            end
            HS_REQ: begin
                if (out_ack) begin
                    state_nx = HS_ACKWAIT;
                end else if (TO_EN && count == LAST) begin
                    state_nx      = HS_IDLE;
                    timeout_pulse = 1'b1;
                end else if (TO_EN) begin
                    // Bounded by LAST, so the counter never wraps.
                    count_nx = count + 1'b1;
                end
            end
            HS_ACKWAIT: begin
                if (!out_ack) begin
                    state_nx   = HS_IDLE;
                    done_pulse = 1'b1;
                end
            end
            default: state_nx = HS_IDLE;
        endcase
    end

    assign busy = (state != HS_IDLE);

endmodule

// File: rtl/de0_cv_pio_dataout_hs.sv
// Avalon-MM slave output PIO: data register on out_port plus a valid/ack
// transfer per DATA write, with sticky DONE/OVERRUN/TIMEOUT flags and IRQ.
// Ports: clk, reset_n (async, active-low); Avalon address/chipselect/write_n/
//   writedata/readdata (latency 1); out_port, out_valid, out_ack; irq (level).
module de0_cv_pio_dataout_hs
    import de0_cv_pio_pkg::*;
#(
    parameter int          DW             = 8,
    parameter logic [31:0] RESET_VALUE    = 32'd0,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [1:0]    address,
    input  logic          chipselect,
    input  logic          write_n,
    input  logic [31:0]   writedata,
    output logic [31:0]   readdata,
    output logic [DW-1:0] out_port,
    output logic          out_valid,
    input  logic          out_ack,
    output logic          irq
);

    logic [DW-1:0] data;
    logic          done, overrun, timeout, irq_en;
    logic          busy, done_pulse, timeout_pulse;
    logic          wr, st_wr, launch, ovr_set;
    logic [DW-1:0] wd;
    logic [31:0]   rd_mux;
    logic          unused_wd;

    assign wr    = chipselect & ~write_n;
    assign st_wr = wr & (address == ADDR_STATUS);
    assign wd    = writedata[DW-1:0];
    assign unused_wd = ^writedata;

    // Data-path writes while a transfer is in flight are dropped and flagged.
    assign ovr_set = wr & busy & (address != ADDR_STATUS);
    assign launch  = wr & ~busy & (address == ADDR_DATA);

    de0_cv_pio_hs_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clk          (clk),
        .reset_n      (reset_n),
        .launch       (launch),
        .out_ack      (out_ack),
        .busy         (busy),
        .out_valid    (out_valid),
        .done_pulse   (done_pulse),
        .timeout_pulse(timeout_pulse)
    );

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:   rd_mux = 32'(data);
            ADDR_STATUS: rd_mux = status_word(busy, done, overrun,
                                              timeout, irq_en);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data     <= RESET_VALUE[DW-1:0];
            done     <= 1'b0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
            irq_en   <= 1'b0;
            readdata <= '0;
        end else begin
            if (wr && !busy) begin
                case (address)
                    ADDR_DATA:     data <= wd;
                    ADDR_OUTSET:   data <= data | wd;
                    ADDR_OUTCLEAR: data <= data & ~wd;
                    default:       data <= data;
                endcase
            end
            // Set beats a same-cycle write-1-to-clear.
            done    <= done_pulse |
                       (done & ~(st_wr & writedata[ST_DONE]));
            overrun <= ovr_set |
                       (overrun & ~(st_wr & writedata[ST_OVERRUN]));
            timeout <= timeout_pulse |
                       (timeout & ~(st_wr & writedata[ST_TIMEOUT]));
            if (st_wr)
                irq_en <= writedata[ST_IRQ_EN];
            readdata <= rd_mux;
        end
    end

    assign out_port = data;
    assign irq      = irq_en & (done | timeout);

endmodule

// File: tb/tb_de0_cv_pio_dataout_hs.sv
// Directed self-checking bench for de0_cv_pio_dataout_hs.
// DUT built with TIMEOUT_CYCLES=8 so the timeout path is reachable quickly.
module tb_de0_cv_pio_dataout_hs;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        out_valid;
    logic        out_ack = 1'b0;
    logic        irq;

    int n_chk = 0;
    int n_ok  = 0;

    always #5 clk = ~clk;

    de0_cv_pio_dataout_hs #(
        .DW(8),
        .RESET_VALUE(32'd0),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port),
        .out_valid(out_valid),
        .out_ack(out_ack),
        .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        @(posedge clk);
        #1;
        d = readdata;
    endtask

    logic [31:0] r;
    int          nv;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // 1: reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_readdata", readdata, 32'h0);
        rd(2'd0, r); chk("rst_data", r, 32'h00);
        rd(2'd1, r); chk("rst_status", r, 32'h000);
        chk("rst_out_port", 32'(out_port), 32'h00);
        chk("rst_irq", 32'(irq), 32'h0);

        // 2: basic handshake
        wr(2'd0, 32'hA5);
        chk("hs_out_port", 32'(out_port), 32'hA5);
        chk("hs_valid_up", 32'(out_valid), 32'h1);
        rd(2'd1, r); chk("hs_status_busy", r, 32'h1);
        out_ack = 1'b1;
        @(posedge clk); #1;
        chk("hs_valid_down", 32'(out_valid), 32'h0);
        rd(2'd1, r); chk("hs_status_ackwait", r, 32'h1);
        out_ack = 1'b0;
        @(posedge clk); #1;
        rd(2'd1, r); chk("hs_status_done", r, 32'h2);
        chk("hs_irq_masked", 32'(irq), 32'h0);
        wr(2'd1, 32'h2);
        rd(2'd1, r); chk("hs_status_clr", r, 32'h0);

        // 3: overrun
        wr(2'd0, 32'hA5);
        wr(2'd0, 32'h3C);
        wr(2'd2, 32'hFF);
        rd(2'd1, r); chk("ovr_status", r, 32'h5);
        chk("ovr_out_port", 32'(out_port), 32'hA5);
        wr(2'd1, 32'h4);
        rd(2'd1, r); chk("ovr_clr", r, 32'h1);
        out_ack = 1'b1;
        wr(2'd0, 32'h11);
        chk("ovr_ack_valid", 32'(out_valid), 32'h0);
        out_ack = 1'b0;
        @(posedge clk); #1;
        rd(2'd1, r); chk("ovr_ack_write", r, 32'h6);
        chk("ovr_ack_port", 32'(out_port), 32'hA5);
        wr(2'd1, 32'hE);
        rd(2'd1, r); chk("ovr_all_clr", r, 32'h0);

        // 4: timeout with IRQ
        wr(2'd1, 32'h100);
        wr(2'd0, 32'h5A);
        chk("to_out_port", 32'(out_port), 32'h5A);
        nv = out_valid ? 1 : 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) nv++;
        end
        chk("to_valid_cycles", 32'(nv), 32'd8);
        rd(2'd1, r); chk("to_status", r, 32'h108);
        chk("to_irq_set", 32'(irq), 32'h1);
        wr(2'd1, 32'h108);
        chk("to_irq_clr", 32'(irq), 32'h0);
        rd(2'd1, r); chk("to_status_clr", r, 32'h100);

        // 5: OUTSET / OUTCLEAR
        wr(2'd3, 32'hFF);
        chk("bit_zero", 32'(out_port), 32'h00);
        wr(2'd2, 32'h0F);
        chk("bit_set_valid", 32'(out_valid), 32'h0);
        chk("bit_set", 32'(out_port), 32'h0F);
        wr(2'd3, 32'h03);
        chk("bit_clr_valid", 32'(out_valid), 32'h0);
        chk("bit_clr", 32'(out_port), 32'h0C);
        rd(2'd0, r); chk("bit_rd_data", r, 32'h0C);
        rd(2'd2, r); chk("bit_rd_outset", r, 32'h0);
        rd(2'd3, r); chk("bit_rd_outclr", r, 32'h0);
        rd(2'd1, r); chk("bit_status", r, 32'h100);

        // 6: async reset mid-transfer
        wr(2'd0, 32'h77);
        chk("ar_valid_up", 32'(out_valid), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid_async", 32'(out_valid), 32'h0);
        chk("ar_port_async", 32'(out_port), 32'h00);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        rd(2'd1, r); chk("ar_status", r, 32'h0);
        chk("ar_out_port", 32'(out_port), 32'h00);
        chk("ar_irq", 32'(irq), 32'h0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
